pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised program-counter unit for the next uCISC core.
- Provides sequential increment, absolute jump, call/return through an internal hardware return-address stack, and single-level interrupt entry/exit.
- Adds a pipeline stall.
- Sits between instruction fetch (consumes current_pc/next_pc) and the execute stage (drives jump/call/ret controls and source_value).

Parameters:
- WIDTH, 16, width of PC and all address values.
- DEPTH, 8, return-stack entries (power of two, >=2).
- RESET_VECTOR, 0, value loaded into PC by reset.
- IRQ_VECTOR, 16'h0010, interrupt entry address (truncated/zero-extended to WIDTH).

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hold all state this cycle.
- store_enabled  input  1  execute stage commits a write this cycle.
- destination_pc  input  1  write targets PC (jump when store_enabled).
- call  input  1  push return address, jump to source_value.
- ret  input  1  pop return address into PC.
- iret  input  1  pop return address into PC, leave interrupt mode.
- irq  input  1  level interrupt request.
- source_value  input  WIDTH  jump/call target.
- current_pc  output  WIDTH  registered PC of the executing instruction.
- next_pc  output  WIDTH  combinational PC to be loaded at next edge.
- in_irq  output  1  registered; interrupt handler active.
- stack_depth  output  $clog2(DEPTH)+1  registered occupancy.
- stack_overflow  output  1  sticky; push attempted while full.
- stack_underflow  output  1  sticky; pop attempted while empty.

Behaviour:
- Reset (synchronous, at posedge):
  - current_pc = RESET_VECTOR; in_irq = 0; stack_depth = 0; both sticky flags = 0.
  - Stack contents are don't-care.
  - Reset overrides every other input, including an in-flight call or irq.
- next_pc is always combinational. current_pc <= next_pc each non-stalled posedge, so latency is 1 cycle.
- stall=1: next_pc = current_pc. No stack, flag or in_irq change. All other controls are ignored.
- Priority when not stalled, highest first:
  1. irq & ~in_irq: push inc (current_pc+1); next_pc = IRQ_VECTOR; in_irq <= 1. Any concurrent jump/call/ret/iret is discarded.
  2. iret: pop; next_pc = popped value; in_irq <= 0. iret with in_irq=0 behaves as ret.
  3. ret: pop; next_pc = popped value.
  4. call: push inc; next_pc = source_value. Call does not require store_enabled.
  5. destination_pc & store_enabled: next_pc = source_value.
  6. Otherwise: next_pc = inc.
- Arithmetic: inc = current_pc + 1 mod 2^WIDTH. All-ones wraps to 0 with no flag.
- Push while stack_depth == DEPTH:
  - Entry dropped; depth unchanged; stack_overflow <= 1.
  - The control transfer (call target or IRQ_VECTOR) still occurs.
- Pop while stack_depth == 0:
  - next_pc = inc; depth stays 0; stack_underflow <= 1.
  - iret still clears in_irq.
- irq held high while in_irq=1 is ignored (no nesting). It is re-sampled on the first non-stalled cycle after iret completes.
- Sticky flags are cleared only by reset.
- The stack is LIFO: push writes at index depth, pop reads index depth-1. The popped value is readable combinationally in the same cycle.

Decomposition:
- Shared package pc_pkg:
  - Enum pc_sel_t {SEL_INC, SEL_JUMP, SEL_CALL, SEL_RET, SEL_IRQ, SEL_HOLD}.
  - Default vector constants.
  - Function encoding the priority above, so decode and verification share it.
- Sub-module pc_return_stack #(WIDTH, DEPTH):
  - Register-array LIFO with push/pop/top/depth/full/empty.
  - Overflow/underflow qualification is done in pc_stack.

Test Plan:
- Reset then 4 idle cycles -> current_pc 0,1,2,3; stack_depth 0; flags 0. Assert reset with current_pc=0x0042 -> 0x0000 next edge.
- At current_pc=0x0005: jump to 0x1234 (store_enabled=1, destination_pc=1) -> current_pc=0x1234, then 0x1235. Same with store_enabled=0 -> 0x0006.
- Nested calls: at 0x0010 call 0x0100, at 0x0100 call 0x0200 -> depth 2; ret -> 0x0101; ret -> 0x0011; depth 0. stall held 3 cycles mid-sequence -> PC and depth frozen.
- DEPTH=8: 9 consecutive calls -> depth 8, stack_overflow=1, PC=last target. ret on empty stack at 0x0030 -> 0x0031, stack_underflow=1.
- irq at current_pc=0x0020 with concurrent call -> current_pc=0x0010, in_irq=1, depth 1. irq held -> no re-entry. iret -> 0x0021, in_irq=0.
- current_pc=0xFFFF idle -> 0x0000, no flags. irq and reset same cycle -> reset wins: PC 0, in_irq 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types, default constants and the control-priority decode for the PC unit.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET,
    SEL_IRQ,
    SEL_HOLD
  } pc_sel_t;

  localparam int unsigned DEFAULT_WIDTH        = 16;
  localparam int unsigned DEFAULT_DEPTH        = 8;
  localparam int unsigned DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEFAULT_IRQ_VECTOR   = 32'h0000_0010;

  // Resolve the concurrent control inputs to a single PC source, highest priority first.
  // iret and ret both map to SEL_RET; the caller uses iret separately to leave interrupt mode.
  function automatic pc_sel_t pc_select(
    input logic stall,
    input logic irq,
    input logic in_irq,
    input logic iret,
    input logic ret,
    input logic call,
    input logic destination_pc,
    input logic store_enabled
  );
    pc_sel_t sel;
    if (stall) begin
      sel = SEL_HOLD;
    end else if (irq && !in_irq) begin
      sel = SEL_IRQ;
    end else if (iret || ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (destination_pc && store_enabled) begin
      sel = SEL_JUMP;
    end else begin
      sel = SEL_INC;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Execute-stage / fetch-side signal bundle of the PC unit.
interface pc_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic             stall;
  logic             store_enabled;
  logic             destination_pc;
  logic             call;
  logic             ret;
  logic             iret;
  logic             irq;
  logic [WIDTH-1:0] source_value;
  logic [WIDTH-1:0] current_pc;
  logic [WIDTH-1:0] next_pc;
  logic             in_irq;
  logic [DW-1:0]    stack_depth;
  logic             stack_overflow;
  logic             stack_underflow;

  // Pipeline side: drives controls, observes the PC.
  modport master (
    output stall, store_enabled, destination_pc, call, ret, iret, irq, source_value,
    input  current_pc, next_pc, in_irq, stack_depth, stack_overflow, stack_underflow
  );

  // PC unit side.
  modport slave (
    input  stall, store_enabled, destination_pc, call, ret, iret, irq, source_value,
    output current_pc, next_pc, in_irq, stack_depth, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/pc_return_stack.sv
// Register-array LIFO for return addresses. Callers must not push while full or pop while
// empty; both are also masked here so the occupancy can never leave [0, DEPTH].
module pc_return_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IW   = $clog2(DEPTH),
  localparam int unsigned DW   = IW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_value,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  // Index decode; rd_idx wraps to DEPTH-1 when full, which is the topmost entry.
  always_comb begin
    wr_idx = depth_q[IW-1:0];
    rd_idx = wr_idx - IW'(1);
    full   = (depth_q == DW'(DEPTH));
    empty  = (depth_q == '0);
    top    = mem_q[rd_idx];
    depth  = depth_q;
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_value;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program-counter unit: increment, jump, call/return via a hardware return stack,
// single-level interrupt entry/exit and pipeline stall.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned IRQ_VECTOR   = DEFAULT_IRQ_VECTOR,
  localparam int unsigned DW          = $clog2(DEPTH) + 1
) (
  input logic       clock,
  input logic       reset,
  pc_stack_if.slave bus
);

  localparam logic [WIDTH-1:0] ResetPc = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] IrqPc   = WIDTH'(IRQ_VECTOR);

  logic [WIDTH-1:0] current_pc_q, next_pc_d, inc;
  logic             in_irq_q, in_irq_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push, pop;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             full, empty;
  pc_sel_t          sel;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_value (inc),
    .top        (top),
    .depth      (depth),
    .full       (full),
    .empty      (empty)
  );

  // Priority decode of the control inputs.
  always_comb begin
    inc = current_pc_q + WIDTH'(1);
    sel = pc_select(bus.stall, bus.irq, in_irq_q, bus.iret, bus.ret, bus.call,
                    bus.destination_pc, bus.store_enabled);
  end

  // Next PC, stack strobes and mode/flag next-state; full/empty qualify push/pop here.
  always_comb begin
    next_pc_d   = current_pc_q;
    push        = 1'b0;
    pop         = 1'b0;
    in_irq_d    = in_irq_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    unique case (sel)
      SEL_HOLD: ;
      SEL_IRQ: begin
        next_pc_d = IrqPc;
        in_irq_d  = 1'b1;
        if (full) overflow_d = 1'b1;
        else      push       = 1'b1;
      end
      SEL_RET: begin
        if (empty) begin
          next_pc_d   = inc;
          underflow_d = 1'b1;
        end else begin
          next_pc_d = top;
          pop       = 1'b1;
        end
        if (bus.iret) in_irq_d = 1'b0;
      end
      SEL_CALL: begin
        next_pc_d = bus.source_value;
        if (full) overflow_d = 1'b1;
        else      push       = 1'b1;
      end
      SEL_JUMP: next_pc_d = bus.source_value;
      SEL_INC:  next_pc_d = inc;
      default:  next_pc_d = inc;
    endcase
  end

  // PC, interrupt mode and sticky flag registers; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      current_pc_q <= ResetPc;
      in_irq_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      current_pc_q <= next_pc_d;
      in_irq_q     <= in_irq_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.current_pc      = current_pc_q;
  assign bus.next_pc         = next_pc_d;
  assign bus.in_irq          = in_irq_q;
  assign bus.stack_depth     = depth;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: a behavioural model predicts each cycle's state, the
// prediction is queued when stimulus is applied and compared after the clock edge.
module tb_pc_stack;

  localparam logic [15:0] RV = 16'h0000;
  localparam logic [15:0] IV = 16'h0010;

  typedef struct {
    logic [15:0] pc;
    logic        in_irq;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  pc_stack_if #(.WIDTH(16), .DEPTH(8)) bus ();

  pc_stack #(
    .WIDTH        (16),
    .DEPTH        (8),
    .RESET_VECTOR (0),
    .IRQ_VECTOR   (32'h10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  exp_t        sb[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc;
  logic        m_in_irq, m_ovf, m_unf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_push(input logic [15:0] v);
    if (m_stack.size() >= 8) m_ovf = 1'b1;
    else m_stack.push_back(v);
  endtask

  // One clock cycle: drive, predict, check next_pc mid-cycle, compare state after the edge.
  task automatic cyc(input bit rst, input bit stl, input bit st, input bit dst, input bit cl,
                     input bit rt, input bit irt, input bit iq, input logic [15:0] src);
    exp_t        e;
    logic [15:0] inc, nxt;
    reset              = rst;
    bus.stall          = stl;
    bus.store_enabled  = st;
    bus.destination_pc = dst;
    bus.call           = cl;
    bus.ret            = rt;
    bus.iret           = irt;
    bus.irq            = iq;
    bus.source_value   = src;
    @(negedge clock);
    inc = m_pc + 16'd1;
    nxt = inc;
    if (rst) begin
      m_pc     = RV;
      m_in_irq = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_stack.delete();
    end else begin
      if (stl) begin
        nxt = m_pc;
      end else if (iq && !m_in_irq) begin
        nxt = IV;
        m_push(inc);
        m_in_irq = 1'b1;
      end else if (irt || rt) begin
        if (m_stack.size() == 0) m_unf = 1'b1;
        else nxt = m_stack.pop_back();
        if (irt) m_in_irq = 1'b0;
      end else if (cl) begin
        m_push(inc);
        nxt = src;
      end else if (st && dst) begin
        nxt = src;
      end
      check_val("next_pc", bus.next_pc, nxt);
      m_pc = nxt;
    end
    e = '{pc: m_pc, in_irq: m_in_irq, depth: 4'(m_stack.size()), ovf: m_ovf, unf: m_unf};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_val("current_pc", bus.current_pc, e.pc);
    check_val("in_irq", bus.in_irq, e.in_irq);
    check_val("stack_depth", bus.stack_depth, e.depth);
    check_val("stack_overflow", bus.stack_overflow, e.ovf);
    check_val("stack_underflow", bus.stack_underflow, e.unf);
  endtask

  task automatic idle();                    cyc(0, 0, 0, 0, 0, 0, 0, 0, 16'h0); endtask
  task automatic rst_c();                   cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0); endtask
  task automatic stall_c();                 cyc(0, 1, 1, 1, 1, 1, 0, 1, 16'hdead); endtask
  task automatic jmp(input logic [15:0] a); cyc(0, 0, 1, 1, 0, 0, 0, 0, a); endtask
  task automatic call_to(input logic [15:0] a); cyc(0, 0, 0, 0, 1, 0, 0, 0, a); endtask
  task automatic do_ret();                  cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0); endtask

  initial begin
    m_pc = 16'hxxxx; m_in_irq = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset and idle increment.
    rst_c();
    rst_c();
    check_val("reset_pc", bus.current_pc, 16'h0000);
    for (int i = 0; i < 4; i++) idle();
    check_val("idle_pc", bus.current_pc, 16'h0004);
    jmp(16'h0042);
    rst_c();
    check_val("reset_from_42", bus.current_pc, 16'h0000);

    // Jump with and without store_enabled.
    jmp(16'h0005);
    jmp(16'h1234);
    check_val("jump_1234", bus.current_pc, 16'h1234);
    idle();
    check_val("after_jump", bus.current_pc, 16'h1235);
    jmp(16'h0005);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 16'h1234);
    check_val("no_store_jump", bus.current_pc, 16'h0006);

    // Nested calls with a stall in the middle.
    jmp(16'h0010);
    call_to(16'h0100);
    call_to(16'h0200);
    check_val("nest_depth", bus.stack_depth, 4'd2);
    for (int i = 0; i < 3; i++) stall_c();
    check_val("stall_pc", bus.current_pc, 16'h0200);
    do_ret();
    check_val("ret1", bus.current_pc, 16'h0101);
    do_ret();
    check_val("ret2", bus.current_pc, 16'h0011);
    check_val("ret_depth", bus.stack_depth, 4'd0);

    // Overflow: nine calls into an eight-entry stack.
    for (int i = 0; i < 9; i++) call_to(16'h0300 + 16'(i * 16));
    check_val("ovf_depth", bus.stack_depth, 4'd8);
    check_val("ovf_flag", bus.stack_overflow, 1'b1);
    check_val("ovf_pc", bus.current_pc, 16'h0380);
    for (int i = 0; i < 8; i++) do_ret();
    jmp(16'h0030);
    do_ret();
    check_val("unf_pc", bus.current_pc, 16'h0031);
    check_val("unf_flag", bus.stack_underflow, 1'b1);
    idle();
    check_val("ovf_sticky", bus.stack_overflow, 1'b1);
    rst_c();

    // Interrupt entry with a concurrent call, no nesting, iret.
    jmp(16'h0020);
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 16'h0400);
    check_val("irq_pc", bus.current_pc, 16'h0010);
    check_val("irq_mode", bus.in_irq, 1'b1);
    check_val("irq_depth", bus.stack_depth, 4'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h0);
    cyc(0, 1, 0, 0, 0, 0, 1, 1, 16'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 16'h0);
    check_val("iret_pc", bus.current_pc, 16'h0021);
    check_val("iret_mode", bus.in_irq, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h0);
    check_val("irq_reenter", bus.current_pc, 16'h0010);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
    check_val("iret_empty_unf", bus.stack_underflow, 1'b1);
    rst_c();

    // Wrap at all-ones, and reset beating irq.
    jmp(16'hffff);
    idle();
    check_val("wrap_pc", bus.current_pc, 16'h0000);
    check_val("wrap_noflag", bus.stack_overflow, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h0);
    cyc(1, 0, 0, 0, 1, 0, 0, 1, 16'h0700);
    check_val("rst_irq_pc", bus.current_pc, 16'h0000);
    check_val("rst_irq_mode", bus.in_irq, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
